alu_op_sequencer: RTL

Controller that sequences the shared 8-bit ALU (alu8) for the CPU core. It accepts 8-bit and 16-bit arithmetic commands over a valid/ready handshake and drives the ALU operand and opcode ports. 16-bit ops run as two chained ALU passes. The block owns the architectural F register, supplies carry-in from it, and returns the result and flags over a valid/ready response channel.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag index and sequencer state definitions for alu8 and its sequencer
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_CP   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_RL   = 4'h8;
  localparam logic [3:0] OP_RR   = 4'h9;
  localparam logic [3:0] OP_BSL  = 4'hA;
  localparam logic [3:0] OP_BSR  = 4'hB;
  localparam logic [3:0] OP_SWAP = 4'hC;
  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;
  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;
  function automatic logic is_wide_legal(input logic [3:0] op);
    return op <= OP_SBC;
  endfunction
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the shared alu8 for 8-bit and chained 16-bit commands and owns the F register
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter logic [7:0] FLAGS_RESET = 8'h00,
  parameter bit WIDE_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_wide,
  input  logic        cmd_flags_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_res,
  output logic [7:0]  rsp_flags,
  output logic        rsp_err,
  output logic [7:0]  flags_q,
  input  logic        flags_load,
  input  logic [7:0]  flags_load_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_res,
  input  logic [7:0]  alu_flags
);
  state_t state, state_d;
  logic [3:0] op_q;
  logic [15:0] a_q, b_q, hi_res;
  logic wide_q, we_q, c_lo, illegal, wb;
  logic [7:0] res_lo, lo_flags, hi_flags;
  assign illegal = op_q >= 4'hD || (wide_q && (!is_wide_legal(op_q) || !WIDE_ENABLE));
  assign hi_res = {alu_res, res_lo};
  assign lo_flags = alu_flags & 8'hF0;
  // Z of a wide op reflects the whole 16-bit result, not just the high pass
  assign hi_flags = {hi_res == 16'h0000, alu_flags[FLAG_N], alu_flags[FLAG_H], alu_flags[FLAG_C], 4'h0};
  assign wb = we_q && ((state == EXEC_LO && !wide_q && !illegal) || state == EXEC_HI);
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    alu_a = 8'h00;
    alu_b = 8'h00;
    alu_opcode = OP_ADD;
    alu_carry_in = 1'b0;
    case (state)
      IDLE: state_d = cmd_valid ? EXEC_LO : IDLE;
      EXEC_LO: begin
        alu_a = a_q[7:0];
        alu_b = b_q[7:0];
        alu_opcode = op_q;
        alu_carry_in = flags_q[FLAG_C];
        state_d = (wide_q && !illegal) ? EXEC_HI : RESP;
      end
      EXEC_HI: begin
        alu_a = a_q[15:8];
        alu_b = b_q[15:8];
        alu_opcode = (op_q == OP_ADD || op_q == OP_ADC) ? OP_ADC : OP_SBC;
        alu_carry_in = c_lo;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= 4'h0;
      a_q <= 16'h0000;
      b_q <= 16'h0000;
      wide_q <= 1'b0;
      we_q <= 1'b0;
      res_lo <= 8'h00;
      c_lo <= 1'b0;
      rsp_res <= 16'h0000;
      rsp_flags <= 8'h00;
      rsp_err <= 1'b0;
      flags_q <= FLAGS_RESET;
    end else begin
      if (cmd_valid && cmd_ready) begin
        op_q <= cmd_op;
        a_q <= cmd_a;
        b_q <= cmd_b;
        wide_q <= cmd_wide;
        we_q <= cmd_flags_we;
      end
      if (state == EXEC_LO) begin
        res_lo <= alu_res;
        c_lo <= alu_flags[FLAG_C];
        if (illegal) begin
          rsp_res <= 16'h0000;
          rsp_flags <= flags_q;
          rsp_err <= 1'b1;
        end else if (!wide_q) begin
          rsp_res <= {8'h00, alu_res};
          rsp_flags <= lo_flags;
          rsp_err <= 1'b0;
        end
      end
      if (state == EXEC_HI) begin
        rsp_res <= hi_res;
        rsp_flags <= hi_flags;
        rsp_err <= 1'b0;
      end
      flags_q <= flags_load ? (flags_load_data & 8'hF0) : wb ? (state == EXEC_HI ? hi_flags : lo_flags) : flags_q;
    end
endmodule
